amer_div_seq: RTL

AMER_DIV_SEQ -- requirements
Module: amer_div_seq

---
 rtl/amer_div_pkg.sv | 14 +
 rtl/amer_div_step.sv | 27 ++
 rtl/amer_div_seq.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/amer_div_pkg.sv
// Shared definitions for the sequential restoring divider.
//   state_t    : FSM encoding (IDLE, CALC, DONE)
//   DW_DEFAULT : default divisor/quotient/remainder width
package amer_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DW_DEFAULT = 8;

endpackage

// File: rtl/amer_div_step.sv
// One combinational restoring-division iteration.
//   rem_in  : partial remainder entering the step (DW+1 bits)
//   din     : next dividend bit, MSB first
//   b       : divisor
//   rem_out : partial remainder after shift and conditional subtract
//   q_bit   : 1 when the divisor was subtracted
module amer_div_step #(
  parameter int DW = 8
) (
  input  logic [DW:0]   rem_in,
  input  logic          din,
  input  logic [DW-1:0] b,
  output logic [DW:0]   rem_out,
  output logic          q_bit
);

  // One extra bit of headroom keeps the compare honest even if rem_in[DW]
  // were ever set; in normal operation rem_in < b so shifted < 2*b.
  logic [DW+1:0] shifted;
  logic [DW+1:0] diff;

  assign shifted = {rem_in, din};
  assign diff    = shifted - {2'b00, b};
  assign q_bit   = (shifted >= {2'b00, b});
  assign rem_out = (DW+1)'(q_bit ? diff : shifted);

endmodule

// File: rtl/amer_div_seq.sv
// Sequential unsigned divider: 2*DW-bit dividend / DW-bit divisor.
// Restoring algorithm, one quotient bit per clock, with valid/ready on
// both sides. Zero divisor and quotient overflow finish immediately.
//
// Optional build macro AMER_DIV_POW2_EN: power-of-two divisors are
// answered by shift/mask in the accept cycle instead of iterating.
//
// Ports:
//   clk, rst           : clock, async active-high reset
//   in_valid/in_ready  : request handshake (Z dividend, B divisor)
//   out_valid/out_ready: result handshake (Q, R, div_zero, ovf)
module amer_div_seq
  import amer_div_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*DW-1:0] Z,
  input  logic [DW-1:0]   B,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   Q,
  output logic [DW-1:0]   R,
  output logic            div_zero,
  output logic            ovf
);

  localparam int CW = $clog2(DW) + 1;

  state_t        state_q, state_d;
  logic [DW:0]   rem_q;
  logic [DW-1:0] zlo_q;
  logic [DW-1:0] b_q;
  logic [CW-1:0] cnt_q;
  logic [DW-1:0] q_q, r_q;
  logic          dz_q, ovf_q;

  logic          accept;
  logic          b_zero, hi_ovf, fast_done, last_iter;
  logic [DW:0]   step_rem;
  logic          step_q;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;

  assign b_zero    = (B == '0);
  // Quotient fits in DW bits only when the upper half is below B.
  assign hi_ovf    = !b_zero && (Z[2*DW-1:DW] >= B);
  assign last_iter = (cnt_q == CW'(DW-1));

`ifdef AMER_DIV_POW2_EN
  logic            is_pow2;
  logic [DW-1:0]   pow2_q;
  logic [DW-1:0]   pow2_r;
  logic [2*DW-1:0] z_shr;

  assign is_pow2 = !b_zero && ((B & (B - 1'b1)) == '0);
  assign pow2_r  = Z[DW-1:0] & (B - 1'b1);

  // Only one bit of B is set on this path, so the last hit is the shift.
  always_comb begin
    z_shr = Z;
    for (int i = 0; i < DW; i++)
      if (B[i]) z_shr = Z >> i;
  end
  assign pow2_q    = z_shr[DW-1:0];
  assign fast_done = b_zero || hi_ovf || is_pow2;
`else
  assign fast_done = b_zero || hi_ovf;
`endif

  // Single step instance, fed from the registered operands every CALC cycle.
  amer_div_step #(.DW(DW)) u_step (
    .rem_in  (rem_q),
    .din     (zlo_q[DW-1]),
    .b       (b_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = fast_done ? DONE : CALC;
      CALC:    if (last_iter) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      zlo_q <= '0;
      b_q   <= '0;
      cnt_q <= '0;
      q_q   <= '0;
      r_q   <= '0;
      dz_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      b_q   <= B;
      zlo_q <= Z[DW-1:0];
      rem_q <= {1'b0, Z[2*DW-1:DW]};
      cnt_q <= '0;
      if (b_zero) begin
        q_q   <= '1;
        r_q   <= '1;
        dz_q  <= 1'b1;
        ovf_q <= 1'b0;
      end else if (hi_ovf) begin
        q_q   <= '1;
        r_q   <= '0;
        dz_q  <= 1'b0;
        ovf_q <= 1'b1;
      end else begin
`ifdef AMER_DIV_POW2_EN
        q_q <= is_pow2 ? pow2_q : '0;
        r_q <= is_pow2 ? pow2_r : '0;
`else
        q_q <= '0;
        r_q <= '0;
`endif
        dz_q  <= 1'b0;
        ovf_q <= 1'b0;
      end
    end else if (state_q == CALC) begin
      rem_q <= step_rem;
      zlo_q <= zlo_q << 1;
      q_q   <= {q_q[DW-2:0], step_q};
      cnt_q <= cnt_q + 1'b1;
      if (last_iter) r_q <= step_rem[DW-1:0];
    end
  end

  assign Q        = q_q;
  assign R        = r_q;
  assign div_zero = dz_q;
  assign ovf      = ovf_q;

endmodule
